bdd_traverse_engine: RTL and testbench

BDD_TRAVERSE_ENGINE -- requirements
Module: bdd_traverse_engine

---
 rtl/bdd_pkg.sv | 38 +++
 rtl/bdd_mac.sv | 26 ++
 rtl/bdd_traverse_engine.sv | 148 ++++++++++++++
 tb/tb_bdd_traverse_engine.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bdd_pkg.sv
// Shared definitions for the BDD traversal engine: FSM states and
// the field layout of node and child memory words.
package bdd_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_MAC,
        S_CMP,
        S_DONE
    } state_t;

    // Child pointers: right pointer sits in the low PTR_W bits, left above it.
    localparam int RPTR_LSB = 0;

    function automatic int lptr_lsb(input int ptr_w);
        return ptr_w;
    endfunction

    // The leaf flag is the bit just above the node address field.
    function automatic int leaf_bit(input int node_aw);
        return node_aw;
    endfunction

    // Node word: coefficients packed from the LSB, threshold on top.
    function automatic int coef_lsb(input int k, input int coef_w);
        return k * coef_w;
    endfunction

    function automatic int thr_lsb(input int n_feat, input int coef_w);
        return n_feat * coef_w;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bdd_mac.sv
// Serial multiply-accumulate: one unsigned feat*coef product per enabled cycle.
module bdd_mac
    import bdd_pkg::*;
#(
    parameter int FEAT_W = 8,
    parameter int COEF_W = 8,
    parameter int ACC_W  = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [FEAT_W-1:0] feat,
    input  logic [COEF_W-1:0] coef,
    output logic [ACC_W-1:0]  acc
);

    // Accumulator cleared at the start of each node, then summed serially.
    always_ff @(posedge clk) begin
        if (rst || clr)
            acc <= '0;
        else if (en)
            acc <= acc + ACC_W'(feat) * ACC_W'(coef);
    end

endmodule

// File: rtl/bdd_traverse_engine.sv
// Walks a binary decision diagram stored in on-chip node/child memories,
// scoring each node with a dot product against a latched feature vector.
module bdd_traverse_engine
    import bdd_pkg::*;
#(
    parameter  int N_FEAT    = 3,
    parameter  int FEAT_W    = 8,
    parameter  int COEF_W    = 8,
    parameter  int NODE_AW   = 8,
    parameter  int MAX_DEPTH = 32,
    localparam int ACC_W     = FEAT_W + COEF_W + $clog2(N_FEAT),
    localparam int NODE_W    = N_FEAT * COEF_W + ACC_W,
    localparam int PTR_W     = NODE_AW + 1,
    localparam int CFG_W     = max2(NODE_W, 2 * PTR_W),
    localparam int DEP_W     = $clog2(MAX_DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic                     cfg_sel,
    input  logic [NODE_AW-1:0]       cfg_addr,
    input  logic [CFG_W-1:0]         cfg_wdata,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_FEAT*FEAT_W-1:0] in_feat,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NODE_AW-1:0]       out_class,
    output logic                     out_err,
    output logic [DEP_W-1:0]         out_depth
);

    localparam int CNT_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam int LEAF  = leaf_bit(NODE_AW);
    localparam int THR   = thr_lsb(N_FEAT, COEF_W);
    localparam int LPTR  = lptr_lsb(PTR_W);
    localparam logic [CNT_W-1:0] LAST_K = CNT_W'(N_FEAT - 1);
    localparam logic [DEP_W-1:0] DEP_MAX = DEP_W'(MAX_DEPTH);

    logic [NODE_W-1:0]  node_mem  [2**NODE_AW];
    logic [2*PTR_W-1:0] child_mem [2**NODE_AW];

    state_t                    state;
    logic [NODE_AW-1:0]        node_addr;
    logic [NODE_W-1:0]         node_q;
    logic [2*PTR_W-1:0]        child_q;
    logic [N_FEAT*FEAT_W-1:0]  feat_q;
    logic [CNT_W-1:0]          mac_cnt;
    logic [DEP_W-1:0]          depth;
    logic [ACC_W-1:0]          acc;
    logic [PTR_W-1:0]          sel;
    logic [DEP_W-1:0]          depth_inc;

    assign out_depth = depth;
    assign depth_inc = depth + 1'b1;
    assign sel = (acc < node_q[THR +: ACC_W]) ? child_q[LPTR +: PTR_W]
                                              : child_q[RPTR_LSB +: PTR_W];

    // Config writes land only while idle; both memories read together in FETCH.
    always_ff @(posedge clk) begin
        if (cfg_we && state == S_IDLE) begin
            if (cfg_sel)
                child_mem[cfg_addr] <= cfg_wdata[2*PTR_W-1:0];
            else
                node_mem[cfg_addr] <= cfg_wdata[NODE_W-1:0];
        end
        if (state == S_FETCH) begin
            node_q  <= node_mem[node_addr];
            child_q <= child_mem[node_addr];
        end
    end

    bdd_mac #(
        .FEAT_W (FEAT_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == S_FETCH),
        .en   (state == S_MAC),
        .feat (feat_q[mac_cnt*FEAT_W +: FEAT_W]),
        .coef (node_q[mac_cnt*COEF_W +: COEF_W]),
        .acc  (acc)
    );

    // Traversal FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_class <= '0;
            out_err   <= 1'b0;
            depth     <= '0;
            node_addr <= '0;
            feat_q    <= '0;
            mac_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        feat_q    <= in_feat;
                        node_addr <= '0;
                        depth     <= '0;
                        in_ready  <= 1'b0;
                        state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    mac_cnt <= '0;
                    state   <= S_MAC;
                end
                S_MAC: begin
                    mac_cnt <= mac_cnt + 1'b1;
                    if (mac_cnt == LAST_K)
                        state <= S_CMP;
                end
                S_CMP: begin
                    depth <= depth_inc;
                    if (sel[LEAF]) begin
                        out_class <= sel[NODE_AW-1:0];
                        out_err   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else if (depth_inc == DEP_MAX) begin
                        out_class <= '0;
                        out_err   <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        node_addr <= sel[NODE_AW-1:0];
                        state     <= S_FETCH;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bdd_traverse_engine.sv
// Directed and randomized checks of bdd_traverse_engine against a
// tree-walking reference model.
module tb_bdd_traverse_engine;

    localparam int NF = 3, FW = 8, CW = 8, AW = 8, MD = 4;
    localparam int ACC_W = 18, PTR_W = 9, CFG_W = 42, DEP_W = 3;
    localparam int LEAF = 256;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cfg_we = 1'b0;
    logic               cfg_sel = 1'b0;
    logic [AW-1:0]      cfg_addr = '0;
    logic [CFG_W-1:0]   cfg_wdata = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [NF*FW-1:0]   in_feat = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [AW-1:0]      out_class;
    logic               out_err;
    logic [DEP_W-1:0]   out_depth;

    bdd_traverse_engine #(
        .N_FEAT (NF), .FEAT_W (FW), .COEF_W (CW), .NODE_AW (AW), .MAX_DEPTH (MD)
    ) dut (
        .clk (clk), .rst (rst),
        .cfg_we (cfg_we), .cfg_sel (cfg_sel), .cfg_addr (cfg_addr), .cfg_wdata (cfg_wdata),
        .in_valid (in_valid), .in_ready (in_ready), .in_feat (in_feat),
        .out_valid (out_valid), .out_ready (out_ready), .out_class (out_class),
        .out_err (out_err), .out_depth (out_depth)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    // Reference tree: pointers >= LEAF are leaves carrying class (p - LEAF).
    int m_coef [256][3];
    int m_thr  [256];
    int m_l    [256];
    int m_r    [256];

    task automatic chk(input string tag, input longint obs, input longint exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_node(input int a, input int c0, input int c1, input int c2, input int thr);
        logic [CFG_W-1:0] w;
        w = '0;
        w[7:0]   = 8'(c0);
        w[15:8]  = 8'(c1);
        w[23:16] = 8'(c2);
        w[24 +: ACC_W] = ACC_W'(thr);
        @(negedge clk);
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 8'(a); cfg_wdata = w;
        @(negedge clk);
        cfg_we = 1'b0;
        m_coef[a][0] = c0; m_coef[a][1] = c1; m_coef[a][2] = c2; m_thr[a] = thr;
    endtask

    task automatic set_child(input int a, input int l, input int r);
        logic [CFG_W-1:0] w;
        w = '0;
        w[17:9] = 9'(l);
        w[8:0]  = 9'(r);
        @(negedge clk);
        cfg_we = 1'b1; cfg_sel = 1'b1; cfg_addr = 8'(a); cfg_wdata = w;
        @(negedge clk);
        cfg_we = 1'b0;
        m_l[a] = l; m_r[a] = r;
    endtask

    // Walk the tree from node 0 until a leaf or the depth limit.
    task automatic model(input logic [23:0] feat, output int cls, output int err, output int dep);
        int a, acc, p;
        a = 0; cls = 0; err = 0; dep = 0;
        for (int d = 1; d <= MD; d++) begin
            acc = m_coef[a][0] * int'(feat[7:0]) + m_coef[a][1] * int'(feat[15:8])
                + m_coef[a][2] * int'(feat[23:16]);
            p = (acc < m_thr[a]) ? m_l[a] : m_r[a];
            dep = d;
            if (p >= LEAF) begin
                cls = p - LEAF;
                return;
            end
            if (d == MD) begin
                err = 1;
                return;
            end
            a = p;
        end
    endtask

    // One traversal: handshake, wait for result, optional stall (with an
    // ignored config write attempt), then accept the result.
    task automatic run(input logic [23:0] feat, input int stall, input bit poke,
                       output int o_cls, output int o_err, output int o_dep, output int o_lat);
        int e_cls, e_err, e_dep, t0;
        bit got;
        model(feat, e_cls, e_err, e_dep);
        @(negedge clk);
        in_feat = feat; in_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin got = 1'b1; break; end
            @(negedge clk);
        end
        chk("in_ready_idle", got, 1);
        t0 = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (out_valid) begin got = 1'b1; break; end
            @(negedge clk);
        end
        chk("out_valid_rise", got, 1);
        o_lat = cyc - t0; o_cls = out_class; o_err = out_err; o_dep = out_depth;
        chk("latency", o_lat, 1 + e_dep * (NF + 2));
        chk("class", o_cls, e_cls);
        chk("err", o_err, e_err);
        chk("depth", o_dep, e_dep);
        chk("in_ready_done", in_ready, 0);
        for (int s = 0; s < stall; s++) begin
            if (poke && s == 0) begin
                cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = '0; cfg_wdata = '0;
            end else if (poke && s == 1) begin
                cfg_we = 1'b1; cfg_sel = 1'b1; cfg_addr = '0; cfg_wdata = 42'h3ffff;
            end else begin
                cfg_we = 1'b0;
            end
            @(negedge clk);
            chk("stall_valid", out_valid, 1);
            chk("stall_class", out_class, e_cls);
            chk("stall_err", out_err, e_err);
            chk("stall_depth", out_depth, e_dep);
            chk("stall_in_ready", in_ready, 0);
        end
        cfg_we = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_in_ready", in_ready, 1);
        chk("post_out_valid", out_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c, e, d, l;
        bit seen;
        logic [23:0] f;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_class", out_class, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_out_depth", out_depth, 0);

        // Single node: acc 80 < 100 -> left leaf 5.
        set_node(0, 1, 2, 3, 100);
        set_child(0, LEAF + 5, LEAF + 6);
        run({8'd10, 8'd20, 8'd10}, 0, 0, c, e, d, l);
        chk("single_class", c, 5);
        chk("single_depth", d, 1);
        chk("single_lat", l, 6);

        // acc 105 >= 100 -> right; then equality at threshold 105 -> right.
        run({8'd15, 8'd20, 8'd20}, 0, 0, c, e, d, l);
        chk("gt_class", c, 6);
        set_node(0, 1, 2, 3, 105);
        run({8'd15, 8'd20, 8'd20}, 0, 0, c, e, d, l);
        chk("eq_class", c, 6);

        // Backpressure: 10-cycle stall with config writes that must be ignored.
        set_node(0, 1, 2, 3, 100);
        run({8'd10, 8'd20, 8'd10}, 10, 1, c, e, d, l);
        run({8'd10, 8'd20, 8'd10}, 0, 0, c, e, d, l);
        chk("stall_mem_kept", c, 5);

        // Chain 0 -> 1 -> 2 -> leaf 9.
        set_node(0, 0, 0, 0, 0);
        set_node(1, 0, 0, 0, 0);
        set_node(2, 0, 0, 0, 0);
        set_child(0, 1, 1);
        set_child(1, 2, 2);
        set_child(2, LEAF + 9, LEAF + 9);
        run({8'd7, 8'd8, 8'd9}, 0, 0, c, e, d, l);
        chk("chain_class", c, 9);
        chk("chain_depth", d, 3);
        chk("chain_lat", l, 16);

        // Self loop at node 0 -> depth limit.
        set_child(0, 0, 0);
        run({8'd1, 8'd2, 8'd3}, 0, 0, c, e, d, l);
        chk("limit_err", e, 1);
        chk("limit_class", c, 0);
        chk("limit_depth", d, MD);

        // Reset during MAC aborts the traversal.
        set_node(0, 1, 2, 3, 100);
        set_child(0, LEAF + 5, LEAF + 6);
        @(negedge clk);
        in_feat = {8'd10, 8'd20, 8'd10}; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("midrst_no_result", seen, 0);
        run({8'd15, 8'd20, 8'd20}, 0, 0, c, e, d, l);
        chk("midrst_after_class", c, 6);

        // Random trees over nodes 0..7 with random feature vectors.
        for (int t = 0; t < 30; t++) begin
            if (t % 5 == 0) begin
                for (int n = 0; n < 8; n++) begin
                    set_node(n, $urandom_range(0, 255), $urandom_range(0, 255),
                             $urandom_range(0, 255), $urandom_range(0, 3 * 255 * 255));
                    set_child(n,
                              ($urandom_range(0, 9) < 6) ? LEAF + $urandom_range(0, 255) : $urandom_range(0, 7),
                              ($urandom_range(0, 9) < 6) ? LEAF + $urandom_range(0, 255) : $urandom_range(0, 7));
                end
            end
            f = 24'($urandom);
            run(f, $urandom_range(0, 3), 0, c, e, d, l);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
